// File: rtl/cv32e40p_pkg.sv
// Shared cv32e40p types: pooling reduction modes and pooling engine states.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    POOL_MAX = 2'b00,
    POOL_AVG = 2'b01,
    POOL_SUM = 2'b10
  } pool_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    POST  = 2'b10,
    WRITE = 2'b11
  } pool_state_e;

endpackage

// File: rtl/cv32e40p_sat_add.sv
// Signed adder of a wide operand and an OUT_W operand, saturated to signed OUT_W.
// Requires IN_W >= OUT_W.
module cv32e40p_sat_add #(
  parameter int IN_W  = 34,
  parameter int OUT_W = 32
) (
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [OUT_W-1:0] b,
  output logic signed [OUT_W-1:0] y
);

  localparam int SUM_W = IN_W + 1;

  logic signed [SUM_W-1:0]   sum;
  logic        [SUM_W-OUT_W:0] top;
  logic                      in_range;

  assign sum = SUM_W'(a) + SUM_W'(b);

  // The sum fits in OUT_W exactly when every bit above the result sign matches it.
  assign top      = sum[SUM_W-1:OUT_W-1];
  assign in_range = (top == '0) || (top == '1);

  always_comb begin
    y = sum[OUT_W-1:0];
    if (!in_range) begin
      y = sum[SUM_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/cv32e40p_pool_post_unit.sv
// Pooling/post-processing engine: streams one window, reduces (max/avg/sum),
// adds bias with saturation, optional ReLU, and returns one result word.
module cv32e40p_pool_post_unit
  import cv32e40p_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int WIN     = 4,
  parameter int LOG_WIN = $clog2(WIN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic              relu_en_i,
  input  logic [DATA_W-1:0] bias_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic              busy_o,
  input  logic              rdata_valid_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              rdata_ready_o,
  output logic              wdata_valid_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic              wdata_ready_i,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);

  localparam int ACC_W = DATA_W + LOG_WIN;
  localparam int CNT_W = (LOG_WIN > 0) ? LOG_WIN : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; the read side is ready only in LOAD, the write side holds
  // valid and data stable in WRITE until ready is seen.

  pool_state_e state, state_nxt;

  logic [1:0]               mode_q;
  logic                     relu_q;
  logic signed [DATA_W-1:0] bias_q;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt;
  logic [DATA_W-1:0]        out_q;

  logic signed [ACC_W-1:0]  d_ext;
  logic signed [ACC_W-1:0]  red;
  logic signed [DATA_W-1:0] sat_out;
  logic [DATA_W-1:0]        post_val;
  logic                     is_max;

  assign d_ext  = ACC_W'($signed(rdata_i));
  // Reserved mode 11 falls through to max.
  assign is_max = (mode_q != POOL_AVG) && (mode_q != POOL_SUM);

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_i) state_nxt = LOAD;
        LOAD:    if (rdata_valid_i && (cnt == CNT_LAST)) state_nxt = POST;
        POST:    state_nxt = WRITE;
        WRITE:   if (wdata_ready_i) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Arithmetic shift floors the average toward minus infinity.
  always_comb begin
    red = acc;
    if (mode_q == POOL_AVG) red = acc >>> LOG_WIN;
  end

  cv32e40p_sat_add #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W)
  ) u_sat_add (
    .a (red),
    .b (bias_q),
    .y (sat_out)
  );

  assign post_val = (relu_q && sat_out[DATA_W-1]) ? '0 : sat_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= '0;
      relu_q   <= 1'b0;
      bias_q   <= '0;
      acc      <= '0;
      cnt      <= '0;
      out_q    <= '0;
      result_o <= '0;
      done_o   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_o <= (state == WRITE) && wdata_ready_i && !flush_i;
      if (!flush_i) begin
        case (state)
          IDLE: begin
            if (start_i) begin
              mode_q <= mode_i;
              relu_q <= relu_en_i;
              bias_q <= bias_i;
              acc    <= '0;
              cnt    <= '0;
            end
          end
          LOAD: begin
            if (rdata_valid_i) begin
              if (is_max) begin
                acc <= ((cnt == '0) || (d_ext > acc)) ? d_ext : acc;
              end else begin
                acc <= acc + d_ext;
              end
              cnt <= cnt + CNT_W'(1);
            end
          end
          POST:  out_q <= post_val;
          WRITE: if (wdata_ready_i) result_o <= out_q;
          default: ;
        endcase
      end
    end
  end

  assign ready_o       = (state == IDLE);
  assign busy_o        = (state != IDLE);
  assign rdata_ready_o = (state == LOAD);
  assign wdata_valid_o = (state == WRITE);
  assign wdata_o       = (state == WRITE) ? out_q : '0;

endmodule

// File: tb/tb_cv32e40p_pool_post_unit.sv
// Randomized self-checking bench for cv32e40p_pool_post_unit against an
// arithmetic reference model of the pooling rules.
`timescale 1ns/1ps
module tb_cv32e40p_pool_post_unit;

  localparam int DATA_W = 32;
  localparam int WIN    = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [1:0]        mode_i = '0;
  logic              relu_en_i = 1'b0;
  logic [DATA_W-1:0] bias_i = '0;
  logic              flush_i = 1'b0;
  logic              rdata_valid_i = 1'b0;
  logic [DATA_W-1:0] rdata_i = '0;
  logic              wdata_ready_i = 1'b0;
  logic              ready_o, busy_o, rdata_ready_o, wdata_valid_o, done_o;
  logic [DATA_W-1:0] wdata_o, result_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int exp_hs = 0;

  logic [DATA_W-1:0] elem [WIN];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] last_result = '0;

  cv32e40p_pool_post_unit #(
    .DATA_W (DATA_W),
    .WIN    (WIN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .mode_i        (mode_i),
    .relu_en_i     (relu_en_i),
    .bias_i        (bias_i),
    .flush_i       (flush_i),
    .ready_o       (ready_o),
    .busy_o        (busy_o),
    .rdata_valid_i (rdata_valid_i),
    .rdata_i       (rdata_i),
    .rdata_ready_o (rdata_ready_o),
    .wdata_valid_o (wdata_valid_o),
    .wdata_o       (wdata_o),
    .wdata_ready_i (wdata_ready_i),
    .done_o        (done_o),
    .result_o      (result_o)
  );

  // clock / cycle counter / event monitor
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && wdata_valid_o && wdata_ready_i && !flush_i) hs_cnt <= hs_cnt + 1;
    if (done_o) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: window reduction, bias, saturation and ReLU in plain 64-bit math.
  function automatic logic [DATA_W-1:0] model(input logic [1:0] mode, input logic relu,
                                              input logic [DATA_W-1:0] bias);
    longint v, q, s;
    if (mode == 2'b01 || mode == 2'b10) begin
      v = 0;
      for (int i = 0; i < WIN; i++) v = v + longint'($signed(elem[i]));
      if (mode == 2'b01) begin
        q = v / WIN;
        if ((v % WIN) != 0 && v < 0) q = q - 1;
        v = q;
      end
    end else begin
      v = longint'($signed(elem[0]));
      for (int i = 1; i < WIN; i++)
        if (longint'($signed(elem[i])) > v) v = longint'($signed(elem[i]));
    end
    s = v + longint'($signed(bias));
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
    if (relu && s < 0) s = 0;
    return s[DATA_W-1:0];
  endfunction

  task automatic set_elems(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
    elem[0] = a; elem[1] = b; elem[2] = c; elem[3] = d;
  endtask

  function automatic logic [DATA_W-1:0] rand_val();
    case ($urandom_range(0, 3))
      0: return DATA_W'($urandom);
      1: return DATA_W'($urandom_range(0, 40)) - DATA_W'(20);
      2: return 32'h7FFF_FFFF - DATA_W'($urandom_range(0, 3));
      default: return 32'h8000_0000 + DATA_W'($urandom_range(0, 3));
    endcase
  endfunction

  // Called at a negedge with the DUT in IDLE; leaves it at the done_o negedge.
  task automatic run_op(input logic [1:0] mode, input logic relu, input logic [DATA_W-1:0] bias,
                        input int gap_min, input int gap_max, input int stall, input int exp_lat);
    logic [DATA_W-1:0] exp;
    int t0;
    int k;
    exp = model(mode, relu, bias);
    exp_q.push_back(exp);
    check_eq("ready_idle", {31'd0, ready_o}, 32'd1);
    start_i = 1'b1; mode_i = mode; relu_en_i = relu; bias_i = bias;
    t0 = cyc;
    @(negedge clk);
    start_i = 1'b0; mode_i = 2'($urandom); relu_en_i = 1'($urandom); bias_i = $urandom;
    check_eq("busy_load", {30'd0, ready_o, busy_o}, 32'd1);
    check_eq("done_pulse_width", {31'd0, done_o}, 32'd0);
    for (int i = 0; i < WIN; i++) begin
      k = $urandom_range(gap_max, gap_min);
      repeat (k) begin
        rdata_valid_i = 1'b0; rdata_i = $urandom;
        @(negedge clk);
      end
      check_eq("rdata_ready", {31'd0, rdata_ready_o}, 32'd1);
      rdata_valid_i = 1'b1; rdata_i = elem[i];
      @(negedge clk);
    end
    rdata_valid_i = 1'b0; rdata_i = $urandom;
    check_eq("post_no_valid", {31'd0, wdata_valid_o}, 32'd0);
    for (int w = 0; w < 8 && !wdata_valid_o; w++) @(negedge clk);
    check_eq("wvalid_seen", {31'd0, wdata_valid_o}, 32'd1);
    if (exp_lat >= 0) check_eq("wvalid_latency", DATA_W'(cyc - t0), DATA_W'(exp_lat));
    repeat (stall) begin
      check_eq("wdata_stable", wdata_o, exp_q[0]);
      check_eq("wvalid_held", {31'd0, wdata_valid_o}, 32'd1);
      check_eq("result_held", result_o, last_result);
      @(negedge clk);
    end
    wdata_ready_i = 1'b1;
    check_eq("wdata", wdata_o, exp_q.pop_front());
    exp_hs++;
    @(negedge clk);
    wdata_ready_i = 1'b0;
    check_eq("done", {31'd0, done_o}, 32'd1);
    check_eq("result", result_o, exp);
    check_eq("ready_after", {30'd0, ready_o, wdata_valid_o}, 32'd2);
    check_eq("wdata_zero", wdata_o, '0);
    if (exp_lat >= 0 && stall == 0) check_eq("done_latency", DATA_W'(cyc - t0), DATA_W'(exp_lat + 1));
    last_result = exp;
  endtask

  // Start, load n elements (n==WIN: flush in WRITE with the sink ready), then flush.
  task automatic abort_op(input int n);
    start_i = 1'b1; mode_i = 2'b10; relu_en_i = 1'b0; bias_i = '0;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      rdata_valid_i = 1'b1; rdata_i = DATA_W'(i + 100);
      @(negedge clk);
    end
    rdata_valid_i = 1'b0;
    if (n == WIN) begin
      for (int w = 0; w < 8 && !wdata_valid_o; w++) @(negedge clk);
      check_eq("abort_wvalid", {31'd0, wdata_valid_o}, 32'd1);
      wdata_ready_i = 1'b1;
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; wdata_ready_i = 1'b0;
    check_eq("flush_idle", {30'd0, ready_o, busy_o}, 32'd2);
    repeat (3) begin
      check_eq("flush_no_write", {30'd0, wdata_valid_o, done_o}, 32'd0);
      check_eq("flush_result", result_o, last_result);
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_in_reset", {26'd0, ready_o, busy_o, rdata_ready_o, wdata_valid_o, done_o, 1'b0}, 32'h20);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_flags", {27'd0, ready_o, busy_o, rdata_ready_o, wdata_valid_o, done_o}, 32'h10);
    check_eq("rst_wdata", wdata_o, '0);
    check_eq("rst_result", result_o, '0);

    set_elems(-32'sd5, 32'd3, 32'd7, -32'sd2);
    run_op(2'b00, 1'b0, 32'd0, 0, 0, 0, WIN + 2);
    set_elems(-32'sd1, -32'sd2, -32'sd3, -32'sd4);
    run_op(2'b01, 1'b0, 32'd0, 0, 0, 0, WIN + 2);
    run_op(2'b01, 1'b1, 32'd0, 0, 0, 0, WIN + 2);
    set_elems(32'd1, 32'd2, 32'd3, 32'd6);
    run_op(2'b01, 1'b0, 32'd0, 0, 0, 0, WIN + 2);
    set_elems(-32'sd8, -32'sd6, -32'sd9, -32'sd7);
    run_op(2'b00, 1'b0, 32'd4, 0, 0, 0, WIN + 2);
    run_op(2'b00, 1'b1, 32'd4, 0, 0, 0, WIN + 2);
    set_elems(32'd10, 32'd20, 32'd30, 32'd40);
    run_op(2'b00, 1'b0, -32'sd4, 0, 0, 0, WIN + 2);
    run_op(2'b11, 1'b0, 32'd0, 0, 0, 0, WIN + 2);
    set_elems(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_op(2'b10, 1'b0, 32'd0, 0, 0, 0, WIN + 2);
    set_elems(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    run_op(2'b10, 1'b0, -32'sd1, 0, 0, 0, WIN + 2);

    set_elems(32'd5, -32'sd9, 32'd12, 32'd1);
    run_op(2'b10, 1'b0, 32'd3, 2, 2, 3, -1);

    abort_op(2);
    set_elems(32'd1, 32'd2, 32'd3, 32'd4);
    run_op(2'b00, 1'b0, 32'd0, 0, 0, 0, WIN + 2);
    abort_op(WIN);

    start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    check_eq("flush_beats_start", {30'd0, ready_o, busy_o}, 32'd2);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < WIN; i++) elem[i] = rand_val();
      run_op(2'($urandom), 1'($urandom), rand_val(), 0, $urandom_range(0, 2),
             $urandom_range(0, 3), -1);
    end

    // Reset asserted while the result is being offered.
    set_elems(32'd9, 32'd8, 32'd7, 32'd6);
    start_i = 1'b1; mode_i = 2'b10; relu_en_i = 1'b0; bias_i = '0;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      rdata_valid_i = 1'b1; rdata_i = elem[i];
      @(negedge clk);
    end
    rdata_valid_i = 1'b0;
    for (int w = 0; w < 8 && !wdata_valid_o; w++) @(negedge clk);
    check_eq("rst_pre_wvalid", {31'd0, wdata_valid_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_flags", {27'd0, ready_o, busy_o, rdata_ready_o, wdata_valid_o, done_o}, 32'h10);
    check_eq("rst_async_wdata", wdata_o, '0);
    check_eq("rst_async_result", result_o, '0);
    last_result = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_elems(-32'sd3, 32'd11, 32'd0, 32'd2);
    run_op(2'b01, 1'b0, 32'd1, 0, 0, 0, WIN + 2);

    repeat (2) @(negedge clk);
    check_eq("handshake_count", DATA_W'(hs_cnt), DATA_W'(exp_hs));
    check_eq("done_count", DATA_W'(done_cnt), DATA_W'(exp_hs));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
